pes_ram_stream_reader: RTL and testbench

- Read-side engine for the 64x8 dual-port RAM (pes_ram_design).
- On a start command it walks a contiguous address window on one RAM port, compensates for the RAM's 1-cycle registered read latency, and emits the words as a valid/ready stream.
- Sits between the RAM's port B and downstream pipeline stages; port A stays with the writer.

---
 rtl/pes_ram_stream_reader.sv | 117 +++++++++++
 tb/tb_pes_ram_stream_reader.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pes_ram_stream_reader.sv
// Read engine for the dual-port RAM: walks an address window on port B and
// re-times the registered read data into a 2-entry valid/ready output buffer.
module pes_ram_stream_reader #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [LEN_W-1:0]  remaining;
  logic              inflight;
  logic [DATA_W-1:0] buf0;
  logic [DATA_W-1:0] buf1;
  logic              vld0;
  logic              vld1;
  logic              pop;
  logic              push;
  logic              issue;
  logic [1:0]        occ;

  // Occupancy seen by the issue rule: buffered + in flight, less this cycle's pop.
  assign pop     = vld0 & m_ready;
  assign push    = inflight;
  assign occ     = 2'(vld0) + 2'(vld1) + 2'(inflight) - 2'(pop);
  assign m_valid = vld0;
  assign m_data  = buf0;
  assign ram_we  = 1'b0;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = (length != '0) ? S_READ : S_DONE;
      end
      S_READ: begin
        issue = (remaining != '0) && (occ < 2'd2);
        if (issue && (remaining == LEN_W'(1))) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // Leave as the final word is accepted so done lands the next cycle.
        if (!inflight && !vld1 && (!vld0 || pop)) state_nxt = S_DONE;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      inflight  <= 1'b0;
      ram_addr  <= '0;
      remaining <= '0;
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt != S_IDLE);
      done     <= (state_nxt == S_DONE);
      inflight <= issue;
      if ((state == S_IDLE) && start) begin
        ram_addr  <= base_addr;
        remaining <= length;
      end else if (issue) begin
        ram_addr  <= ram_addr + ADDR_W'(1);
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

  // Shift-style FIFO: entry 0 is always the head, so m_data comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf0 <= '0;
      buf1 <= '0;
      vld0 <= 1'b0;
      vld1 <= 1'b0;
    end else if (pop) begin
      if (vld1) begin
        buf0 <= buf1;
        if (push) buf1 <= ram_q;
        else      vld1 <= 1'b0;
      end else if (push) begin
        buf0 <= ram_q;
      end else begin
        vld0 <= 1'b0;
      end
    end else if (push) begin
      if (vld0) begin
        buf1 <= ram_q;
        vld1 <= 1'b1;
      end else begin
        buf0 <= ram_q;
        vld0 <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pes_ram_stream_reader.sv
// Bench for pes_ram_stream_reader: behavioural RAM plus an address-window model
// of the expected word stream, with fixed and randomized transfers.
module tb_pes_ram_stream_reader;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 7;
  localparam int DEPTH = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  length = '0;
  logic              busy, done, ram_we, m_valid;
  logic              m_ready = 1'b0;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_q, m_data;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              we_a = 1'b0;
  logic [ADDR_W-1:0] addr_a = '0;
  logic [DATA_W-1:0] din_a = '0;

  int checks = 0;
  int errors = 0;
  int ref_mem [DEPTH];
  logic [DATA_W-1:0] got [$];
  logic [DATA_W-1:0] exp [$];
  logic [ADDR_W-1:0] addr_log [$];
  int first_valid, done_cyc, last_hs, ndone, stable_viol, ahead_viol, busy_viol;
  bit timed_out;
  bit pat [6];

  pes_ram_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  // Dual-port RAM: port A write, port B registered read.
  always @(posedge clk) begin
    if (we_a) mem[addr_a] <= din_a;
    if (!ram_we) ram_q <= mem[ram_addr];
  end

  task automatic fill(input bit rnd);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      we_a = 1'b1;
      addr_a = ADDR_W'(i);
      ref_mem[i] = rnd ? int'($urandom_range(255)) : 'h10 + i;
      din_a = DATA_W'(ref_mem[i]);
    end
    @(negedge clk);
    we_a = 1'b0;
  endtask

  task automatic build_exp(input int base, input int len);
    exp.delete();
    for (int i = 0; i < len; i++) exp.push_back(DATA_W'(ref_mem[(base + i) % DEPTH]));
  endtask

  // Runs one transfer from a negedge; mode 0 ready=1, 1 fixed pattern, 2 random.
  task automatic do_xfer(input int base, input int len, input int mode, input bit poke);
    bit prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    int budget = 40 + len * 8;
    got.delete(); addr_log.delete();
    first_valid = -1; done_cyc = -1; last_hs = -1; ndone = 0;
    stable_viol = 0; ahead_viol = 0; busy_viol = 0; timed_out = 1'b1;
    build_exp(base, len);
    start = 1'b1; base_addr = ADDR_W'(base); length = LEN_W'(len); m_ready = 1'b0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && busy && !done && ($urandom_range(2) == 0)) begin
        start = 1'b1;
        base_addr = ADDR_W'($urandom);
        length = LEN_W'($urandom);
      end
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = pat[cyc % 6];
        default: m_ready = ($urandom_range(99) < 60);
      endcase
      if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data)) stable_viol++;
      if (m_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (len < DEPTH && busy === 1'b1 &&
          ((int'(ram_addr) - base) & (DEPTH - 1)) > got.size() + 2) ahead_viol++;
      if (busy === 1'b1 && (addr_log.size() == 0 || addr_log[$] != ram_addr))
        addr_log.push_back(ram_addr);
      if (done === 1'b1) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        if (busy !== 1'b0) busy_viol++;
        timed_out = 1'b0;
        break;
      end
      if (done_cyc < 0 && busy !== 1'b1) busy_viol++;
      if (m_valid === 1'b1 && m_ready) begin
        got.push_back(m_data);
        last_hs = cyc;
      end
      prev_stall = (m_valid === 1'b1) && !m_ready;
      prev_data = m_data;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, done, m_valid, ram_we} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {busy, done, m_valid, ram_we});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (m_data !== '0 || ram_addr !== '0) begin
      errors++; $display("FAIL reset_regs m_data %h ram_addr %0d exp 0 0", m_data, ram_addr);
    end
    checks++;
    if ({busy, done, m_valid} !== 3'b0) begin
      errors++; $display("FAIL reset_idle got %b exp 000", {busy, done, m_valid});
    end
  endtask

  task automatic test_basic();
    int bad = 0;
    do_xfer(2, 4, 0, 0);
    for (int i = 0; i < exp.size(); i++) if (i >= got.size() || got[i] !== exp[i]) bad++;
    checks++;
    if (bad != 0 || got.size() != 4) begin
      errors++; $display("FAIL basic_data got %0d words %0d bad, exp 4 words 12..15", got.size(), bad);
    end
    checks++;
    if (first_valid != 3) begin
      errors++; $display("FAIL basic_latency got %0d exp 3", first_valid);
    end
    checks++;
    if (last_hs - first_valid != 3) begin
      errors++; $display("FAIL basic_throughput got span %0d exp 3", last_hs - first_valid);
    end
    checks++;
    if (timed_out || ndone != 1 || done_cyc - last_hs != 1) begin
      errors++; $display("FAIL basic_done got pulses %0d delay %0d exp 1 1", ndone, done_cyc - last_hs);
    end
    checks++;
    if (busy_viol != 0) begin
      errors++; $display("FAIL basic_busy got %0d violations exp 0", busy_viol);
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    do_xfer(0, 5, 1, 0);
    for (int i = 0; i < exp.size(); i++) if (i >= got.size() || got[i] !== exp[i]) bad++;
    checks++;
    if (bad != 0 || got.size() != 5) begin
      errors++; $display("FAIL bp_data got %0d words %0d bad, exp 5 words", got.size(), bad);
    end
    checks++;
    if (stable_viol != 0) begin
      errors++; $display("FAIL bp_stable got %0d violations exp 0", stable_viol);
    end
    checks++;
    if (ahead_viol != 0) begin
      errors++; $display("FAIL bp_ahead got %0d violations exp 0", ahead_viol);
    end
    checks++;
    if (timed_out || ndone != 1 || done_cyc - last_hs != 1) begin
      errors++; $display("FAIL bp_done got pulses %0d delay %0d exp 1 1", ndone, done_cyc - last_hs);
    end
  endtask

  task automatic test_wrap();
    int bad = 0;
    logic [ADDR_W-1:0] exp_addr [4];
    exp_addr[0] = 6'd62; exp_addr[1] = 6'd63; exp_addr[2] = 6'd0; exp_addr[3] = 6'd1;
    do_xfer(62, 4, 0, 0);
    for (int i = 0; i < exp.size(); i++) if (i >= got.size() || got[i] !== exp[i]) bad++;
    checks++;
    if (bad != 0 || got.size() != 4) begin
      errors++; $display("FAIL wrap_data got %0d words %0d bad, exp 4E 4F 10 11", got.size(), bad);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) if (i >= addr_log.size() || addr_log[i] !== exp_addr[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL wrap_addr got %0d bad of %0d logged, exp 62 63 0 1", bad, addr_log.size());
    end
  endtask

  task automatic test_edge_lengths();
    int bad = 0;
    do_xfer(0, 0, 0, 0);
    checks++;
    if (timed_out || ndone != 1 || done_cyc > 2) begin
      errors++; $display("FAIL len0_done got pulses %0d at %0d exp 1 within 2", ndone, done_cyc);
    end
    checks++;
    if (first_valid != -1) begin
      errors++; $display("FAIL len0_valid got first valid %0d exp none", first_valid);
    end
    do_xfer(0, 64, 0, 0);
    for (int i = 0; i < exp.size(); i++) if (i >= got.size() || got[i] !== exp[i]) bad++;
    checks++;
    if (bad != 0 || got.size() != 64) begin
      errors++; $display("FAIL len64_data got %0d words %0d bad, exp 64", got.size(), bad);
    end
    checks++;
    if (timed_out || ndone != 1 || last_hs - first_valid != 63) begin
      errors++; $display("FAIL len64_done got pulses %0d span %0d exp 1 63", ndone, last_hs - first_valid);
    end
  endtask

  task automatic test_busy_start();
    int bad = 0;
    do_xfer(10, 6, 2, 1);
    for (int i = 0; i < exp.size(); i++) if (i >= got.size() || got[i] !== exp[i]) bad++;
    checks++;
    if (bad != 0 || got.size() != 6) begin
      errors++; $display("FAIL busy_start_data got %0d words %0d bad, exp 6", got.size(), bad);
    end
    checks++;
    if (timed_out || ndone != 1 || busy_viol != 0) begin
      errors++; $display("FAIL busy_start_done got pulses %0d busy_viol %0d exp 1 0", ndone, busy_viol);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int bad = 0;
    start = 1'b1; base_addr = '0; length = LEN_W'(6); m_ready = 1'b1;
    for (int cyc = 1; cyc < 40 && n < 2; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (m_valid === 1'b1 && m_ready) n++;
    end
    checks++;
    if (n != 2) begin
      errors++; $display("FAIL rstmid_progress got %0d accepted exp 2", n);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({m_valid, busy, done} !== 3'b0) begin
      errors++; $display("FAIL rstmid_async got %b exp 000", {m_valid, busy, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_xfer(5, 2, 0, 0);
    for (int i = 0; i < exp.size(); i++) if (i >= got.size() || got[i] !== exp[i]) bad++;
    checks++;
    if (bad != 0 || got.size() != 2 || ndone != 1) begin
      errors++; $display("FAIL rstmid_restart got %0d words %0d bad %0d done, exp 15 16 one done",
                         got.size(), bad, ndone);
    end
  endtask

  task automatic test_random();
    fill(1'b1);
    for (int t = 0; t < 10; t++) begin
      int bad = 0;
      int b = int'($urandom_range(DEPTH - 1));
      int l = int'($urandom_range(70, 1));
      do_xfer(b, l, int'($urandom_range(2)), 1'($urandom_range(1)));
      for (int i = 0; i < exp.size(); i++) if (i >= got.size() || got[i] !== exp[i]) bad++;
      checks++;
      if (bad != 0 || got.size() != l) begin
        errors++; $display("FAIL rand_data[%0d] base %0d len %0d got %0d words %0d bad", t, b, l, got.size(), bad);
      end
      checks++;
      if (timed_out || ndone != 1 || stable_viol != 0) begin
        errors++; $display("FAIL rand_ctrl[%0d] got pulses %0d stalls %0d exp 1 0", t, ndone, stable_viol);
      end
    end
  endtask

  initial begin
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b0; pat[5] = 1'b1;
    test_reset();
    fill(1'b0);
    test_basic();
    test_backpressure();
    test_wrap();
    test_edge_lengths();
    test_busy_start();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
